// File: rtl/noc_axi4_bridge_pkg.sv
// Shared types and helpers for the NoC-to-AXI4 write deserializer.
// Optional payload byte swap is selected with NOC_AXI4_BRIDGE_WDESER_BSWAP_EN.
package noc_axi4_bridge_pkg;

    localparam int unsigned WDESER_MAX_PAY = 8;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        HDR2,
        PAY,
        OUT
    } wdeser_state_t;

    // Size code 0 means a zero-byte write; code n otherwise means 2^(n-1) bytes.
    function automatic logic [2:0] size_code2log(input logic [2:0] code);
        return (code == 3'd0) ? 3'd0 : code - 3'd1;
    endfunction

endpackage

// File: rtl/noc_axi4_bridge_wstrb_gen.sv
// Combinational lane-write mask for the current payload flit and final line strobe.
module noc_axi4_bridge_wstrb_gen
    import noc_axi4_bridge_pkg::*;
(
    input  logic [5:0]  off,
    input  logic [2:0]  code,
    input  logic [7:0]  pcnt,
    output logic [7:0]  lane_mask,
    output logic [63:0] strb
);

    logic [6:0]  bytes;
    logic [5:0]  off_al;
    logic [8:0]  lane;
    logic [63:0] ones;

    always_comb begin
        bytes  = (code == 3'd0) ? 7'd0 : 7'(1 << (code - 3'd1));
        off_al = off & ~6'(bytes - 7'd1);
        ones   = (bytes == 7'd64) ? '1 : ((64'd1 << bytes) - 64'd1);
        strb   = ones << off_al;

        lane      = 9'(off_al[5:3]) + 9'(pcnt);
        lane_mask = '0;
        // Sub-flit sizes replicate flit 0 into every lane of the line.
        if (code < 3'd4) begin
            lane_mask = (pcnt == 8'd0) ? 8'hFF : 8'h00;
        end else if ((pcnt < 8'(WDESER_MAX_PAY)) && (lane < 9'd8)) begin
            lane_mask[lane[2:0]] = 1'b1;
        end
    end

endmodule

// File: rtl/noc_axi4_bridge_wdeser.sv
// Collects one OpenPiton write request from the NoC and presents an assembled line + strobe.
// Define NOC_AXI4_BRIDGE_WDESER_BSWAP_EN to byte-reverse each payload flit before placement.
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 512
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 64
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 6
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 3
`endif
`ifndef MSG_LENGTH
`define MSG_LENGTH 29:22
`endif
`ifndef MSG_ADDR
`define MSG_ADDR 39:0
`endif
`ifndef MSG_DATA_SIZE
`define MSG_DATA_SIZE 42:40
`endif

module noc_axi4_bridge_wdeser
    import noc_axi4_bridge_pkg::*;
#(
    parameter int unsigned FLIT_W = 64,
    parameter int unsigned LINE_W = `AXI4_DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flit_val,
    input  logic [FLIT_W-1:0]               flit_data,
    output logic                            flit_rdy,
    output logic                            req_val,
    output logic [`AXI4_ADDR_WIDTH-1:0]     req_addr,
    output logic [`MSG_DATA_SIZE_WIDTH-1:0] req_size_log,
    output logic [`AXI4_ID_WIDTH-1:0]       req_id,
    output logic [LINE_W-1:0]               req_data,
    output logic [LINE_W/8-1:0]             req_strb,
    input  logic                            req_rdy
);

    wdeser_state_t     state;
    logic [7:0]        len;
    logic [7:0]        pcnt;
    logic [2:0]        code;
    logic              flit_go;
    logic              last_pay;
    logic [FLIT_W-1:0] pay_flit;
    logic [7:0]        lane_mask;
    logic [63:0]       strb;

    assign flit_rdy = (state != OUT);
    assign flit_go  = flit_val & flit_rdy;
    assign last_pay = (8'(pcnt + 8'd1) == 8'(len - 8'd2));

`ifdef NOC_AXI4_BRIDGE_WDESER_BSWAP_EN
    always_comb begin
        pay_flit = '0;
        for (int i = 0; i < FLIT_W / 8; i++) begin
            pay_flit[8*i +: 8] = flit_data[FLIT_W-8-8*i +: 8];
        end
    end
`else
    assign pay_flit = flit_data;
`endif

    noc_axi4_bridge_wstrb_gen u_wstrb_gen (
        .off       (req_addr[5:0]),
        .code      (code),
        .pcnt      (pcnt),
        .lane_mask (lane_mask),
        .strb      (strb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HDR0;
            len          <= '0;
            pcnt         <= '0;
            code         <= '0;
            req_val      <= 1'b0;
            req_addr     <= '0;
            req_size_log <= '0;
            req_id       <= '0;
            req_data     <= '0;
            req_strb     <= '0;
        end else begin
            unique case (state)
                HDR0: if (flit_go) begin
                    len   <= flit_data[`MSG_LENGTH];
                    state <= HDR1;
                end
                HDR1: if (flit_go) begin
                    req_addr     <= `AXI4_ADDR_WIDTH'(flit_data[`MSG_ADDR]);
                    code         <= flit_data[`MSG_DATA_SIZE];
                    req_size_log <= size_code2log(flit_data[`MSG_DATA_SIZE]);
                    state        <= HDR2;
                end
                HDR2: if (flit_go) begin
                    pcnt <= '0;
                    if (len > 8'd2) begin
                        state <= PAY;
                    end else begin
                        req_strb <= strb;
                        req_val  <= 1'b1;
                        state    <= OUT;
                    end
                end
                PAY: if (flit_go) begin
                    for (int i = 0; i < LINE_W / FLIT_W; i++) begin
                        if (lane_mask[i]) req_data[i*FLIT_W +: FLIT_W] <= pay_flit;
                    end
                    pcnt <= pcnt + 8'd1;
                    if (last_pay) begin
                        req_strb <= strb;
                        req_val  <= 1'b1;
                        state    <= OUT;
                    end
                end
                OUT: if (req_rdy) begin
                    // Line buffer starts clean for the next message.
                    req_val  <= 1'b0;
                    req_id   <= req_id + 1'b1;
                    req_data <= '0;
                    req_strb <= '0;
                    state    <= HDR0;
                end
                default: state <= HDR0;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_axi4_bridge_wdeser.sv
// Self-checking bench for noc_axi4_bridge_wdeser: vector table plus scoreboard of expected requests.
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 512
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 64
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 6
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 3
`endif

module tb_noc_axi4_bridge_wdeser;

    logic         clk;
    logic         rst_n;
    logic         flit_val;
    logic [63:0]  flit_data;
    logic         flit_rdy;
    logic         req_val;
    logic [63:0]  req_addr;
    logic [2:0]   req_size_log;
    logic [5:0]   req_id;
    logic [511:0] req_data;
    logic [63:0]  req_strb;
    logic         req_rdy;

    noc_axi4_bridge_wdeser #(
        .FLIT_W (64),
        .LINE_W (512)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flit_val     (flit_val),
        .flit_data    (flit_data),
        .flit_rdy     (flit_rdy),
        .req_val      (req_val),
        .req_addr     (req_addr),
        .req_size_log (req_size_log),
        .req_id       (req_id),
        .req_data     (req_data),
        .req_strb     (req_strb),
        .req_rdy      (req_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  addr;
        logic [2:0]   slog;
        logic [5:0]   id;
        logic [511:0] data;
        logic [63:0]  strb;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [2:0]  code;
        int          npay;
        logic [63:0] base;
        logic [63:0] step;
        logic [63:0] exp_strb;
        logic [2:0]  exp_slog;
    } vec_t;

    exp_t         sb[$];
    vec_t         vecs[8];
    logic [63:0]  pay[12];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           exp_id  = 0;

    logic         held_val;
    logic [511:0] held_data;
    logic [136:0] held_meta;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lane_byte(input logic [63:0] f, input int j);
`ifdef NOC_AXI4_BRIDGE_WDESER_BSWAP_EN
        return f[8*(7-j) +: 8];
`else
        return f[8*j +: 8];
`endif
    endfunction

    // Byte-level reference: strobe window and per-byte data source.
    function automatic exp_t model(input logic [63:0] addr, input logic [2:0] code,
                                   input int npay, input logic [63:0] p[12], input int id);
        exp_t e;
        int   bytes;
        int   off;
        bytes  = (code == 3'd0) ? 0 : (1 << (int'(code) - 1));
        off    = int'(addr[5:0]);
        if (bytes > 0) off = off - (off % bytes);
        e.addr = {24'b0, addr[39:0]};
        e.slog = (code == 3'd0) ? 3'd0 : code - 3'd1;
        e.id   = 6'(id);
        e.data = '0;
        e.strb = '0;
        for (int b = 0; b < 64; b++) begin
            if (b >= off && b < off + bytes) e.strb[b] = 1'b1;
            if (bytes >= 8) begin
                if (b >= off && (b - off) / 8 < npay && (b - off) / 8 < 8)
                    e.data[8*b +: 8] = lane_byte(p[(b - off) / 8], (b - off) % 8);
            end else if (npay > 0) begin
                e.data[8*b +: 8] = lane_byte(p[0], b % 8);
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            held_val <= 1'b0;
        end else begin
            if (req_val && held_val) begin
                check("hold_data", req_data, held_data);
                check("hold_meta", {req_addr, req_size_log, req_id, req_strb}, held_meta);
            end
            if (req_val && req_rdy) begin
                if (sb.size() == 0) begin
                    check("unexpected_req", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("req_addr", req_addr, e.addr);
                    check("req_size_log", req_size_log, e.slog);
                    check("req_id", req_id, e.id);
                    check("req_strb", req_strb, e.strb);
                    check("req_data", req_data, e.data);
                end
            end
            held_val  <= req_val;
            held_data <= req_data;
            held_meta <= {req_addr, req_size_log, req_id, req_strb};
        end
    end

    task automatic send_flit(input logic [63:0] d, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                flit_val = 1'b0;
                @(posedge clk); #1;
            end
        end
        flit_val  = 1'b1;
        flit_data = d;
        n = 0;
        while (!flit_rdy) begin
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                $display("FAIL flit_rdy_timeout: got 0 expected 1");
                n_fail++;
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $fatal(1, "flit_rdy never asserted");
            end
        end
        @(posedge clk); #1;
        flit_val = 1'b0;
    endtask

    task automatic send_msg(input logic [63:0] addr, input logic [2:0] code, input int npay,
                            input logic [63:0] p[12], input bit gaps, input bit ovr,
                            input logic [63:0] xstrb, input logic [2:0] xslog);
        exp_t e;
        e = model(addr, code, npay, p, exp_id);
        if (ovr) begin
            e.strb = xstrb;
            e.slog = xslog;
        end
        sb.push_back(e);
        exp_id++;
        send_flit({34'b0, 8'(npay + 2), 22'b0}, gaps);
        send_flit({21'b0, code, addr[39:0]}, gaps);
        send_flit(64'hCAFE_F00D_0BAD_BEEF, gaps);
        for (int k = 0; k < npay; k++) send_flit(p[k], gaps);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        flit_val = 1'b0;
        sb.delete();
        exp_id = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{64'h8000_0040, 3'd7, 8, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111,
                    64'hFFFF_FFFF_FFFF_FFFF, 3'd6};
        vecs[1] = '{64'h1000_0024, 3'd3, 1, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0,
                    64'h0000_00F0_0000_0000, 3'd2};
        vecs[2] = '{64'h2000_0038, 3'd5, 2, 64'hA0A1_A2A3_A4A5_A6A7, 64'h0102_0304_0506_0708,
                    64'hFFFF_0000_0000_0000, 3'd4};
        vecs[3] = '{64'h3000_0008, 3'd4, 1, 64'h0123_4567_89AB_CDEF, 64'h0,
                    64'h0000_0000_0000_FF00, 3'd3};
        vecs[4] = '{64'h4000_003F, 3'd1, 1, 64'h5A5A_5A5A_5A5A_5AC3, 64'h0,
                    64'h8000_0000_0000_0000, 3'd0};
        vecs[5] = '{64'h5000_0010, 3'd0, 0, 64'h0, 64'h0,
                    64'h0000_0000_0000_0000, 3'd0};
        vecs[6] = '{64'h6000_002C, 3'd6, 4, 64'h1000_2000_3000_4000, 64'h0101_0101_0101_0101,
                    64'hFFFF_FFFF_0000_0000, 3'd5};
        vecs[7] = '{64'h7000_0013, 3'd2, 1, 64'h7766_5544_3322_1100, 64'h0,
                    64'h0000_0000_000C_0000, 3'd1};

        rst_n     = 1'b0;
        flit_val  = 1'b0;
        flit_data = '0;
        req_rdy   = 1'b1;
        held_val  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_flit_rdy", flit_rdy, 1'b1);
        check("rst_req_val", req_val, 1'b0);
        check("rst_req_id", req_id, 6'd0);
        check("rst_req_data", req_data, '0);
        check("rst_req_strb", req_strb, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 12; k++) pay[k] = vecs[i].base + 64'(k) * vecs[i].step;
            send_msg(vecs[i].addr, vecs[i].code, vecs[i].npay, pay, 1'b0, 1'b1,
                     vecs[i].exp_strb, vecs[i].exp_slog);
            check("lat_req_val", req_val, 1'b1);
            check("lat_flit_rdy", flit_rdy, 1'b0);
            wait_drain();
        end

        // len = 12 on a 64 B write: two excess flits, gap-free then with random gaps.
        for (int k = 0; k < 12; k++) pay[k] = 64'h0F0E_0D0C_0B0A_0908 * 64'(k + 3);
        send_msg(64'h9000_0000, 3'd7, 10, pay, 1'b0, 1'b0, '0, '0);
        wait_drain();
        send_msg(64'h9000_0000, 3'd7, 10, pay, 1'b1, 1'b0, '0, '0);
        wait_drain();

        // Reset after HDR1: outputs clear asynchronously and the partial message is lost.
        send_flit({34'b0, 8'd3, 22'b0}, 1'b0);
        send_flit({21'b0, 3'd4, 40'h00_A000_0018}, 1'b0);
        rst_n    = 1'b0;
        flit_val = 1'b0;
        sb.delete();
        exp_id = 0;
        #1;
        check("arst_req_addr", req_addr, 64'd0);
        check("arst_req_id", req_id, 6'd0);
        check("arst_req_val", req_val, 1'b0);
        check("arst_flit_rdy", flit_rdy, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pay[0] = 64'hFEDC_BA98_7654_3210;
        send_msg(64'hB000_0020, 3'd4, 1, pay, 1'b0, 1'b0, '0, '0);
        wait_drain();

        // Backpressure: hold req_rdy low for 20 cycles, then a back-to-back message.
        do_reset();
        req_rdy = 1'b0;
        pay[0] = 64'h1357_9BDF_2468_ACE0;
        send_msg(64'hC000_0030, 3'd4, 1, pay, 1'b0, 1'b0, '0, '0);
        repeat (20) begin
            @(posedge clk); #1;
            check("stall_req_val", req_val, 1'b1);
            check("stall_flit_rdy", flit_rdy, 1'b0);
        end
        req_rdy = 1'b1;
        @(posedge clk); #1;
        check("post_go_flit_rdy", flit_rdy, 1'b1);
        pay[0] = 64'h0246_8ACE_1357_9BDF;
        send_msg(64'hD000_0008, 3'd4, 1, pay, 1'b0, 1'b0, '0, '0);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
